// File: rtl/console_writer_pkg.sv
// Shared terminal geometry, ASCII codes and state/command types for the console writer,
// terminal and debugger.
package console_writer_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;

  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_BS     = 8'h08;
  localparam logic [7:0] CH_FF     = 8'h0C;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;
  localparam logic [7:0] BLANK     = CH_SPACE;

  typedef enum logic [1:0] {
    IDLE,
    CLR_LINE,
    CLR_SCREEN
  } state_e;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_INC,
    CUR_NEWLINE,
    CUR_CR,
    CUR_BS,
    CUR_HOME
  } cur_cmd_e;

  function automatic logic isPrintable(input logic [7:0] c);
    return (c >= PRINT_MIN) && (c <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/console_writer_cursor.sv
// Cursor tracker: column, row and the row's base address, kept without a multiplier
// by stepping rowBase in COLS increments.
module console_cursor
  import console_writer_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  cur_cmd_e          cmd_i,
  output logic [6:0]        col_o,
  output logic [4:0]        row_o,
  output logic [ADDR_W-1:0] rowBase_o,
  output logic              wrap_o
);

  localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);

  logic [6:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic [ADDR_W-1:0] rowBase_q, rowBase_d;
  logic              advance;

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    rowBase_d = rowBase_q;
    advance   = 1'b0;
    case (cmd_i)
      CUR_INC: begin
        if (col_q == LAST_COL) begin
          col_d   = '0;
          advance = 1'b1;
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      CUR_NEWLINE: begin
        col_d   = '0;
        advance = 1'b1;
      end
      CUR_CR: col_d = '0;
      CUR_BS: begin
        if (col_q != '0) col_d = col_q - 7'd1;
      end
      CUR_HOME: begin
        col_d     = '0;
        row_d     = '0;
        rowBase_d = '0;
      end
      default: ;
    endcase
    // No scrolling: the bottom row wraps straight back to the top of the screen.
    if (advance) begin
      if (row_q == LAST_ROW) begin
        row_d     = '0;
        rowBase_d = '0;
      end else begin
        row_d     = row_q + 5'd1;
        rowBase_d = rowBase_q + ROW_STEP;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      col_q     <= '0;
      row_q     <= '0;
      rowBase_q <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      rowBase_q <= rowBase_d;
    end
  end

  assign col_o     = col_q;
  assign row_o     = row_q;
  assign rowBase_o = rowBase_q;
  assign wrap_o    = (col_q == LAST_COL);

endmodule

// File: rtl/console_writer.sv
// Character-stream front end for the text terminal: decodes bytes into registered
// single-cycle text RAM writes and runs line/screen blanking.
module console_writer
  import console_writer_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  input  logic              clear,
  output logic              busy,
  output logic [ADDR_W-1:0] terminal_addr,
  output logic              terminal_write,
  output logic [7:0]        terminal_data,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row
);

  localparam logic [ADDR_W-1:0] LINE_LAST   = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] SCREEN_LAST = ADDR_W'(ROWS * COLS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clrIdx_q, clrIdx_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              clrWrite_q, clrWrite_d;
  cur_cmd_e          curCmd;
  logic [ADDR_W-1:0] rowBase;
  logic              curWrap;
  logic              accept;
  logic [ADDR_W-1:0] cursorAddr;

  console_cursor u_cursor (
    .clock     (clock),
    .reset     (reset),
    .cmd_i     (curCmd),
    .col_o     (cursor_col),
    .row_o     (cursor_row),
    .rowBase_o (rowBase),
    .wrap_o    (curWrap)
  );

  assign char_ready = reset && (state_q == IDLE) && !clear;
  assign accept     = char_valid && char_ready;
  assign cursorAddr = rowBase + ADDR_W'(cursor_col);

  always_comb begin
    state_d    = state_q;
    clrIdx_d   = clrIdx_q;
    write_d    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    clrWrite_d = 1'b0;
    curCmd     = CUR_NONE;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d  = CLR_SCREEN;
          clrIdx_d = '0;
        end else if (accept) begin
          if (isPrintable(char_data)) begin
            write_d = 1'b1;
            addr_d  = cursorAddr;
            data_d  = char_data;
            curCmd  = CUR_INC;
            if (curWrap) begin
              state_d  = CLR_LINE;
              clrIdx_d = '0;
            end
          end else begin
            case (char_data)
              CH_LF: begin
                curCmd   = CUR_NEWLINE;
                state_d  = CLR_LINE;
                clrIdx_d = '0;
              end
              CH_CR: curCmd = CUR_CR;
              CH_BS: curCmd = CUR_BS;
              CH_FF: begin
                state_d  = CLR_SCREEN;
                clrIdx_d = '0;
              end
              default: ;
            endcase
          end
        end
      end
      CLR_LINE: begin
        // A clear abandons the line blanking mid-way and restarts from address 0.
        if (clear) begin
          state_d  = CLR_SCREEN;
          clrIdx_d = '0;
        end else begin
          write_d    = 1'b1;
          clrWrite_d = 1'b1;
          addr_d     = rowBase + clrIdx_q;
          data_d     = BLANK;
          if (clrIdx_q == LINE_LAST) state_d = IDLE;
          else clrIdx_d = clrIdx_q + 1'b1;
        end
      end
      CLR_SCREEN: begin
        write_d    = 1'b1;
        clrWrite_d = 1'b1;
        addr_d     = clrIdx_q;
        data_d     = BLANK;
        if (clrIdx_q == SCREEN_LAST) begin
          state_d = IDLE;
          curCmd  = CUR_HOME;
        end else begin
          clrIdx_d = clrIdx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      clrIdx_q   <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      clrWrite_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clrIdx_q   <= clrIdx_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      clrWrite_q <= clrWrite_d;
    end
  end

  // busy also covers the trailing blank strobe that lands after the FSM is back in IDLE.
  assign busy           = (state_q != IDLE) || clrWrite_q;
  assign terminal_write = write_q;
  assign terminal_addr  = addr_q;
  assign terminal_data  = data_q;

endmodule

// File: tb/tb_console_writer.sv
// Directed self-checking bench for console_writer with hand-computed expected writes.
module tb_console_writer;
  import console_writer_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              charValid = 1'b0;
  logic [7:0]        charData = 8'h00;
  logic              clear = 1'b0;
  logic              charReady;
  logic              busy;
  logic [ADDR_W-1:0] terminalAddr;
  logic              terminalWrite;
  logic [7:0]        terminalData;
  logic [6:0]        cursorCol;
  logic [4:0]        cursorRow;

  int checkCount = 0;
  int errorCount = 0;

  console_writer dut (
    .clock          (clock),
    .reset          (reset),
    .char_valid     (charValid),
    .char_data      (charData),
    .char_ready     (charReady),
    .clear          (clear),
    .busy           (busy),
    .terminal_addr  (terminalAddr),
    .terminal_write (terminalWrite),
    .terminal_data  (terminalData),
    .cursor_col     (cursorCol),
    .cursor_row     (cursorRow)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic c);
    charValid = v;
    charData  = d;
    clear     = c;
    tick();
  endtask

  task automatic sendByte(input logic [7:0] d);
    applyStimulus(1'b1, d, 1'b0);
    charValid = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    charValid = 1'b0;
    clear = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  // Snapshot of the write port plus busy as one comparable word.
  function automatic logic [31:0] wrWord(input logic w, input logic [ADDR_W-1:0] a,
                                         input logic [7:0] d, input logic b);
    return {10'b0, w, a, d, b};
  endfunction

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;

    $display("[TB] reset");
    reset = 1'b0;
    tick();
    tick();
    checkOutput("rst_write", 32'(terminalWrite), 32'd0);
    checkOutput("rst_addr", 32'(terminalAddr), 32'd0);
    checkOutput("rst_data", 32'(terminalData), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cursor", {20'b0, cursorRow, cursorCol}, 32'd0);
    checkOutput("rst_ready_low", 32'(charReady), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("rst_ready_high", 32'(charReady), 32'd1);

    $display("[TB] single printable");
    sendByte(8'h41);
    checkOutput("A_write", wrWord(terminalWrite, terminalAddr, terminalData, 1'b0),
                wrWord(1'b1, 12'd0, 8'h41, 1'b0));
    checkOutput("A_col", 32'(cursorCol), 32'd1);
    checkOutput("A_ready", 32'(charReady), 32'd1);
    tick();
    checkOutput("A_single_strobe", 32'(terminalWrite), 32'd0);

    $display("[TB] full row wrap and line clear");
    doReset();
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'b1, 8'h78, 1'b0);
      checkOutput($sformatf("x_%0d", i), wrWord(terminalWrite, terminalAddr, terminalData, 1'b0),
                  wrWord(1'b1, 12'(i), 8'h78, 1'b0));
    end
    charValid = 1'b0;
    for (int j = 0; j < 80; j++) begin
      tick();
      checkOutput($sformatf("lblank_%0d", j), wrWord(terminalWrite, terminalAddr, terminalData, busy),
                  wrWord(1'b1, 12'(80 + j), 8'h20, 1'b1));
    end
    tick();
    checkOutput("wrap_done_write", 32'(terminalWrite), 32'd0);
    checkOutput("wrap_done_busy", 32'(busy), 32'd0);
    checkOutput("wrap_cursor", {20'b0, cursorRow, cursorCol}, {20'b0, 5'd1, 7'd0});
    checkOutput("wrap_ready", 32'(charReady), 32'd1);

    $display("[TB] LF at bottom row");
    doReset();
    for (int r = 0; r < 29; r++) begin
      sendByte(CH_LF);
      waitIdle("lf_setup_idle");
    end
    for (int c = 0; c < 5; c++) sendByte(8'h61);
    checkOutput("bottom_cursor", {20'b0, cursorRow, cursorCol}, {20'b0, 5'd29, 7'd5});
    sendByte(CH_LF);
    checkOutput("lf_nowrite", 32'(terminalWrite), 32'd0);
    checkOutput("lf_wrap_cursor", {20'b0, cursorRow, cursorCol}, 32'd0);
    for (int j = 0; j < 80; j++) begin
      tick();
      checkOutput($sformatf("lf_blank_%0d", j), wrWord(terminalWrite, terminalAddr, terminalData, 1'b0),
                  wrWord(1'b1, 12'(j), 8'h20, 1'b0));
    end
    tick();
    checkOutput("lf_done_write", 32'(terminalWrite), 32'd0);

    $display("[TB] backspace, CR and ignored bytes");
    doReset();
    applyStimulus(1'b1, 8'h41, 1'b0);
    checkOutput("bs_A", wrWord(terminalWrite, terminalAddr, terminalData, 1'b0),
                wrWord(1'b1, 12'd0, 8'h41, 1'b0));
    applyStimulus(1'b1, 8'h42, 1'b0);
    checkOutput("bs_B", wrWord(terminalWrite, terminalAddr, terminalData, 1'b0),
                wrWord(1'b1, 12'd1, 8'h42, 1'b0));
    applyStimulus(1'b1, CH_BS, 1'b0);
    checkOutput("bs_nowrite", 32'(terminalWrite), 32'd0);
    checkOutput("bs_col", 32'(cursorCol), 32'd1);
    applyStimulus(1'b1, 8'h43, 1'b0);
    checkOutput("bs_C", wrWord(terminalWrite, terminalAddr, terminalData, 1'b0),
                wrWord(1'b1, 12'd1, 8'h43, 1'b0));
    checkOutput("bs_final_col", 32'(cursorCol), 32'd2);
    applyStimulus(1'b1, 8'h01, 1'b0);
    checkOutput("ignored_nowrite", 32'(terminalWrite), 32'd0);
    checkOutput("ignored_col", 32'(cursorCol), 32'd2);
    applyStimulus(1'b1, CH_CR, 1'b0);
    charValid = 1'b0;
    checkOutput("cr_nowrite", 32'(terminalWrite), 32'd0);
    checkOutput("cr_col", 32'(cursorCol), 32'd0);
    sendByte(CH_BS);
    checkOutput("bs0_nowrite", 32'(terminalWrite), 32'd0);
    checkOutput("bs0_col", 32'(cursorCol), 32'd0);

    $display("[TB] clear beats char_valid");
    doReset();
    sendByte(8'h5A);
    charValid = 1'b1;
    charData  = 8'h41;
    clear     = 1'b1;
    #1;
    checkOutput("clr_ready_low", 32'(charReady), 32'd0);
    tick();
    clear = 1'b0;
    checkOutput("clr_first_nowrite", 32'(terminalWrite), 32'd0);
    checkOutput("clr_busy", 32'(busy), 32'd1);
    bad = 0;
    for (int k = 0; k < 2400; k++) begin
      tick();
      if (wrWord(terminalWrite, terminalAddr, terminalData, 1'b0) !== wrWord(1'b1, 12'(k), 8'h20, 1'b0))
        bad++;
    end
    checkOutput("clr_screen_bad_strobes", 32'(bad), 32'd0);
    checkOutput("clr_home", {20'b0, cursorRow, cursorCol}, 32'd0);
    tick();
    charValid = 1'b0;
    checkOutput("clr_then_A", wrWord(terminalWrite, terminalAddr, terminalData, 1'b0),
                wrWord(1'b1, 12'd0, 8'h41, 1'b0));

    $display("[TB] reset during screen clear");
    applyStimulus(1'b0, 8'h00, 1'b1);
    clear = 1'b0;
    for (int k = 0; k < 500; k++) tick();
    checkOutput("pre_rst_writing", 32'(terminalWrite), 32'd1);
    checkOutput("pre_rst_col", 32'(cursorCol), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("mid_rst_write", 32'(terminalWrite), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_cursor", {20'b0, cursorRow, cursorCol}, 32'd0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (terminalWrite !== 1'b0) bad++;
    end
    checkOutput("post_rst_writes", 32'(bad), 32'd0);

    $display("[TB] clear aborts line clear");
    sendByte(CH_LF);
    for (int k = 0; k < 5; k++) tick();
    checkOutput("abort_pre", wrWord(terminalWrite, terminalAddr, terminalData, 1'b0),
                wrWord(1'b1, 12'd84, 8'h20, 1'b0));
    applyStimulus(1'b0, 8'h00, 1'b1);
    clear = 1'b0;
    checkOutput("abort_nowrite", 32'(terminalWrite), 32'd0);
    tick();
    checkOutput("abort_restart", wrWord(terminalWrite, terminalAddr, terminalData, 1'b0),
                wrWord(1'b1, 12'd0, 8'h20, 1'b0));
    waitIdle("abort_idle");
    checkOutput("abort_home", {20'b0, cursorRow, cursorCol}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/console_writer.md
Name: console_writer

Overview:
- Character-stream front end for the text terminal. Sits directly upstream of the terminal text RAM write port.
- Accepts bytes on a valid/ready handshake and tracks a cursor. Converts printable characters and control codes into single-cycle text RAM writes (terminal_addr/terminal_write/terminal_data).
- Lets the CPU (through a future MMIO port) or the debugger print text without computing screen addresses.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, rows per screen
- ADDR_W, 12, terminal address width; ROWS*COLS must be at most 2^ADDR_W
- BLANK, 8'h20, fill character for clears

Ports:
- clock  in  1  system clock (terminal domain, 25 MHz)
- reset  in  1  synchronous, active-low reset
- char_valid  in  1  char_data holds a byte to consume
- char_data  in  8  byte (ASCII)
- char_ready  out  1  block can accept a byte this cycle
- clear  in  1  level-sampled request: blank the screen and home the cursor
- busy  out  1  high while a line or screen clear is in progress
- terminal_addr  out  ADDR_W  text RAM address (row*COLS+col)
- terminal_write  out  1  single-cycle write strobe
- terminal_data  out  8  byte written
- cursor_col  out  7  current column, 0..COLS-1
- cursor_row  out  5  current row, 0..ROWS-1

Behaviour:
- Reset, sampled on clock edge with reset==0:
  - state IDLE; cursor 0,0; row_base 0
  - terminal_write 0, terminal_addr 0, terminal_data 0; busy 0
  - char_ready 0 during reset, then 1
  - Screen contents are untouched.
- Write outputs are registered. A byte accepted on edge N produces its write strobe in cycle N+1.
- Handshake:
  - A byte is accepted when char_valid & char_ready on an edge.
  - char_ready = (state==IDLE) & ~clear.
  - char_data must be held stable while valid & ~ready.
- States: IDLE, CLR_LINE, CLR_SCREEN.
- IDLE byte decode:
  - 0x20..0x7E: write at row_base+col; col+1. If col==COLS-1, col becomes 0 and the cursor moves to the next row (see "row advance" below). Back-to-back accepts allowed, throughput 1 byte/cycle.
  - 0x0A LF: col 0, row advance.
  - 0x0D CR: col 0, no write.
  - 0x08 BS: col-1 if col>0, else no change; no write.
  - 0x0C FF: same as clear.
  - Any other byte is consumed and ignored: no write, cursor unchanged.
- Row advance:
  - row+1 and row_base+COLS.
  - If row==ROWS-1, wrap to row 0 and row_base 0. No scrolling.
  - Every row advance then enters CLR_LINE on the new row.
- CLR_LINE:
  - Writes BLANK at row_base+0..COLS-1, one per cycle: COLS strobes on consecutive cycles.
  - busy=1 and char_ready=0 throughout.
  - Returns to IDLE after the last write; the cursor stays at col 0 of the new row.
- CLR_SCREEN:
  - Entered from IDLE or CLR_LINE when clear==1 or FF is accepted.
  - Writes BLANK at addresses 0..ROWS*COLS-1 in ascending order, one per cycle.
  - On the last write, cursor 0,0, row_base 0, then IDLE.
  - clear held high during CLR_SCREEN does not restart it. If clear is still high on return to IDLE, a further clear starts.
- Priority:
  - reset > clear > char accept.
  - clear asserted with char_valid in the same cycle: the byte is not accepted (ready 0) and the clear starts.
  - clear during CLR_LINE aborts the line clear at its current address; CLR_SCREEN starts at 0 the next cycle.
- Address arithmetic:
  - No multiplier. row_base is a register maintained by ±COLS steps.
  - terminal_addr = row_base + col, zero-extended to ADDR_W.
- terminal_write is never high for two consecutive cycles at the same address, except repeated printable input.

Decomposition:
- Shared package holds:
  - state enum (IDLE/CLR_LINE/CLR_SCREEN)
  - ASCII constants CH_LF, CH_CR, CH_BS, CH_FF, CH_SPACE, PRINT_MIN/PRINT_MAX
  - terminal geometry constants COLS/ROWS/ADDR_W, shared with the terminal and debugger
- Natural sub-module: console_cursor. It holds col/row/row_base, with inc/newline/home/backspace commands and a wrap flag. The FSM and write-port registering stay in console_writer.

Test Plan:
- Reset (reset=0 for 2 cycles), then send 'A' (0x41) → one write strobe next cycle: addr 0, data 0x41; cursor_col 1; char_ready stays 1.
- Send 80 'x' back-to-back from cursor 0,0 → 80 consecutive strobes at addrs 0..79. Then 80 strobes of 0x20 at addrs 80..159 with busy=1. Finally cursor 1,0 and char_ready returns to 1.
- At cursor row 29, col 5, send LF → cursor 0,0; 80 blank writes at addrs 0..79; no write at 29*80+5.
- Send "AB", BS, 'C' → writes 0x41@0, 0x42@1, 0x43@1; final cursor_col 2. BS at col 0 → no write, cursor unchanged.
- Pulse clear for 1 cycle together with char_valid=1 (0x41) → byte not accepted. 2400 strobes of 0x20 at addrs 0..2399; cursor 0,0; then 0x41 accepted and written at addr 0.
- Assert reset=0 at the 500th cycle of a screen clear → next cycle terminal_write=0, busy=0, cursor 0,0, state IDLE. No further writes occur.
